// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter: default sizing
// constants and the next-PC source selector.
package pc_pkg;

  localparam int PC_W_DEF        = 10;
  localparam int HALT_ADDR_DEF   = 63;
  localparam int STACK_DEPTH_DEF = 4;
  localparam int BRANCH_SKIP_DEF = 2;

  typedef enum logic [2:0] {
    SEL_HOLD   = 3'd0,
    SEL_INC    = 3'd1,
    SEL_BRANCH = 3'd2,
    SEL_REL    = 3'd3,
    SEL_JUMP   = 3'd4,
    SEL_CALL   = 3'd5,
    SEL_RET    = 3'd6
  } pc_sel_e;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO. Push writes at sp and increments; pop decrements and
// exposes the entry below sp. Illegal push/pop requests are ignored here.
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int PC_W        = PC_W_DEF
) (
  input  logic            CLK,
  input  logic            init,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [SP_W-1:0]  sp_r;
  logic [PC_W-1:0]  mem_r [STACK_DEPTH];
  logic [IDX_W-1:0] wr_idx_s;
  logic [IDX_W-1:0] rd_idx_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (sp_r == SP_W'(STACK_DEPTH));
  assign empty     = (sp_r == {SP_W{1'b0}});
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign wr_idx_s  = IDX_W'(sp_r);
  assign rd_idx_s  = IDX_W'(sp_r - SP_W'(1));
  assign top       = mem_r[rd_idx_s];

  // Stack pointer: reset clears it, push and pop are mutually exclusive.
  always_ff @(posedge CLK) begin
    if (init) begin
      sp_r <= {SP_W{1'b0}};
    end else if (push_ok_s) begin
      sp_r <= sp_r + SP_W'(1);
    end else if (pop_ok_s) begin
      sp_r <= sp_r - SP_W'(1);
    end else begin
      sp_r <= sp_r;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge CLK) begin
    if (push_ok_s && !init) begin
      mem_r[wr_idx_s] <= push_data;
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Fetch-stage program counter with relative jumps, branch skip, stall and a
// hardware call/return stack; raises a sticky halt past HALT_ADDR or on stack faults.
module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int PC_W        = PC_W_DEF,
  parameter int HALT_ADDR   = HALT_ADDR_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int BRANCH_SKIP = BRANCH_SKIP_DEF
) (
  input  logic            CLK,
  input  logic            init,
  input  logic            stall,
  input  logic            jump_en,
  input  logic            rel_en,
  input  logic            branch_en,
  input  logic            call_en,
  input  logic            ret_en,
  input  logic [PC_W-1:0] destination,
  input  logic [PC_W-1:0] offset,
  output logic [PC_W-1:0] PC,
  output logic            halt,
  output logic            stack_full,
  output logic            stack_empty,
  output logic            stack_err
);

  localparam logic [PC_W-1:0] HALT_LIM = PC_W'(HALT_ADDR);
  localparam logic [PC_W-1:0] SKIP     = PC_W'(BRANCH_SKIP);
  localparam logic [PC_W-1:0] ONE      = PC_W'(1);

  logic [PC_W-1:0] pc_r;
  logic            halt_r;
  logic            err_r;

  pc_sel_e         sel_s;
  logic            push_s;
  logic            pop_s;
  logic            fault_s;
  logic            halt_set_s;
  logic [PC_W-1:0] pc_nxt_s;
  logic [PC_W-1:0] pc_inc_s;
  logic [PC_W-1:0] top_s;
  logic            full_s;
  logic            empty_s;

  assign pc_inc_s = pc_r + ONE;

  pc_ret_stack #(
    .STACK_DEPTH(STACK_DEPTH),
    .PC_W       (PC_W)
  ) u_stack (
    .CLK      (CLK),
    .init     (init),
    .push     (push_s),
    .pop      (pop_s),
    .push_data(pc_inc_s),
    .top      (top_s),
    .full     (full_s),
    .empty    (empty_s)
  );

  // Priority encoder: only the highest-priority request acts this cycle.
  always_comb begin
    sel_s      = SEL_INC;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    fault_s    = 1'b0;
    halt_set_s = 1'b0;
    if (halt_r) begin
      sel_s = SEL_HOLD;
    end else if (pc_r > HALT_LIM) begin
      sel_s      = SEL_HOLD;
      halt_set_s = 1'b1;
    end else if (stall) begin
      sel_s = SEL_HOLD;
    end else if (ret_en) begin
      if (empty_s) begin
        sel_s      = SEL_HOLD;
        fault_s    = 1'b1;
        halt_set_s = 1'b1;
      end else begin
        sel_s = SEL_RET;
        pop_s = 1'b1;
      end
    end else if (call_en) begin
      // Overflow is fatal: no push, PC frozen, halt raised.
      if (full_s) begin
        sel_s      = SEL_HOLD;
        fault_s    = 1'b1;
        halt_set_s = 1'b1;
      end else begin
        sel_s  = SEL_CALL;
        push_s = 1'b1;
      end
    end else if (jump_en) begin
      sel_s = SEL_JUMP;
    end else if (rel_en) begin
      sel_s = SEL_REL;
    end else if (branch_en) begin
      sel_s = SEL_BRANCH;
    end else begin
      sel_s = SEL_INC;
    end
  end

  // Next-PC mux; all arithmetic wraps modulo 2^PC_W.
  always_comb begin
    pc_nxt_s = pc_r;
    case (sel_s)
      SEL_HOLD:   pc_nxt_s = pc_r;
      SEL_INC:    pc_nxt_s = pc_inc_s;
      SEL_BRANCH: pc_nxt_s = pc_r + SKIP;
      SEL_REL:    pc_nxt_s = pc_r + offset;
      SEL_JUMP:   pc_nxt_s = destination;
      SEL_CALL:   pc_nxt_s = destination;
      SEL_RET:    pc_nxt_s = top_s;
      default:    pc_nxt_s = pc_r;
    endcase
  end

  // PC and sticky halt/error state.
  always_ff @(posedge CLK) begin
    if (init) begin
      pc_r   <= {PC_W{1'b0}};
      halt_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      pc_r   <= pc_nxt_s;
      halt_r <= halt_r | halt_set_s;
      err_r  <= err_r | fault_s;
    end
  end

  assign PC          = pc_r;
  assign halt        = halt_r;
  assign stack_err   = err_r;
  assign stack_full  = full_s;
  assign stack_empty = empty_s;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit: directed vectors push their expected
// post-edge state; a monitor pops and compares after every rising edge.
module tb_pc_stack_unit;

  localparam int PC_W = 10;

  localparam logic [6:0] K_N = 7'b0000000;
  localparam logic [6:0] K_I = 7'b1000000;
  localparam logic [6:0] K_S = 7'b0100000;
  localparam logic [6:0] K_R = 7'b0010000;
  localparam logic [6:0] K_C = 7'b0001000;
  localparam logic [6:0] K_J = 7'b0000100;
  localparam logic [6:0] K_L = 7'b0000010;
  localparam logic [6:0] K_B = 7'b0000001;

  logic            CLK;
  logic            init, stall, jump_en, rel_en, branch_en, call_en, ret_en;
  logic [PC_W-1:0] destination, offset;
  logic [PC_W-1:0] PC;
  logic            halt, stack_full, stack_empty, stack_err;

  typedef struct {
    string           nm;
    logic [PC_W-1:0] pc;
    logic            h;
    logic            f;
    logic            e;
    logic            er;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_vec = 0;
  int   miscompares = 0;

  pc_stack_unit dut (
    .CLK        (CLK),
    .init       (init),
    .stall      (stall),
    .jump_en    (jump_en),
    .rel_en     (rel_en),
    .branch_en  (branch_en),
    .call_en    (call_en),
    .ret_en     (ret_en),
    .destination(destination),
    .offset     (offset),
    .PC         (PC),
    .halt       (halt),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .stack_err  (stack_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic vec(input string nm, input logic [6:0] ctl,
                     input logic [PC_W-1:0] d, input logic [PC_W-1:0] o,
                     input logic [PC_W-1:0] epc, input logic eh,
                     input logic ef, input logic ee, input logic eer);
    exp_t x;
    @(negedge CLK);
    {init, stall, ret_en, call_en, jump_en, rel_en, branch_en} = ctl;
    destination = d;
    offset      = o;
    x.nm = nm; x.pc = epc; x.h = eh; x.f = ef; x.e = ee; x.er = eer;
    exp_q.push_back(x);
  endtask

  always @(posedge CLK) begin
    #1;
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      n_vec++;
      if ({PC, halt, stack_full, stack_empty, stack_err} !==
          {cur.pc, cur.h, cur.f, cur.e, cur.er}) begin
        miscompares++;
        $display("FAIL %s: got pc=%0d halt=%b full=%b empty=%b err=%b, expected pc=%0d halt=%b full=%b empty=%b err=%b",
                 cur.nm, PC, halt, stack_full, stack_empty, stack_err,
                 cur.pc, cur.h, cur.f, cur.e, cur.er);
      end
    end
  end

  initial begin
    {init, stall, ret_en, call_en, jump_en, rel_en, branch_en} = 7'b0;
    destination = 10'd0;
    offset      = 10'd0;

    vec("reset", K_I, 10'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++)
      vec("idle", K_N, 10'd0, 10'd0, 10'(i), 1'b0, 1'b0, 1'b1, 1'b0);

    vec("jmp10",  K_J, 10'd10, 10'd0,     10'd10, 1'b0, 1'b0, 1'b1, 1'b0);
    vec("rel_m3", K_L, 10'd0,  10'h3FD,   10'd7,  1'b0, 1'b0, 1'b1, 1'b0);
    vec("branch", K_B, 10'd0,  10'd0,     10'd9,  1'b0, 1'b0, 1'b1, 1'b0);
    vec("jmp40",  K_J, 10'd40, 10'd0,     10'd40, 1'b0, 1'b0, 1'b1, 1'b0);

    vec("jmp5",   K_J, 10'd5,  10'd0, 10'd5,  1'b0, 1'b0, 1'b1, 1'b0);
    vec("call20", K_C, 10'd20, 10'd0, 10'd20, 1'b0, 1'b0, 1'b0, 1'b0);
    vec("sub21",  K_N, 10'd0,  10'd0, 10'd21, 1'b0, 1'b0, 1'b0, 1'b0);
    vec("sub22",  K_N, 10'd0,  10'd0, 10'd22, 1'b0, 1'b0, 1'b0, 1'b0);
    vec("ret6",   K_R, 10'd0,  10'd0, 10'd6,  1'b0, 1'b0, 1'b1, 1'b0);

    vec("call30",    K_C, 10'd30, 10'd0, 10'd30, 1'b0, 1'b0, 1'b0, 1'b0);
    vec("call50",    K_C, 10'd50, 10'd0, 10'd50, 1'b0, 1'b0, 1'b0, 1'b0);
    vec("lifo_ret1", K_R, 10'd0,  10'd0, 10'd31, 1'b0, 1'b0, 1'b0, 1'b0);
    vec("lifo_ret2", K_R, 10'd0,  10'd0, 10'd7,  1'b0, 1'b0, 1'b1, 1'b0);
    vec("underflow", K_R, 10'd0,  10'd0, 10'd7,  1'b1, 1'b0, 1'b1, 1'b1);
    vec("uf_frozen", K_N, 10'd0,  10'd0, 10'd7,  1'b1, 1'b0, 1'b1, 1'b1);
    vec("uf_init",   K_I, 10'd0,  10'd0, 10'd0,  1'b0, 1'b0, 1'b1, 1'b0);

    vec("nest1",      K_C, 10'd30, 10'd0, 10'd30, 1'b0, 1'b0, 1'b0, 1'b0);
    vec("nest2",      K_C, 10'd31, 10'd0, 10'd31, 1'b0, 1'b0, 1'b0, 1'b0);
    vec("nest3",      K_C, 10'd32, 10'd0, 10'd32, 1'b0, 1'b0, 1'b0, 1'b0);
    vec("nest4_full", K_C, 10'd33, 10'd0, 10'd33, 1'b0, 1'b1, 1'b0, 1'b0);
    vec("overflow",   K_C, 10'd34, 10'd0, 10'd33, 1'b1, 1'b1, 1'b0, 1'b1);
    vec("of_jump",    K_J, 10'd5,  10'd0, 10'd33, 1'b1, 1'b1, 1'b0, 1'b1);
    vec("of_init",    K_I, 10'd0,  10'd0, 10'd0,  1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 1; i <= 64; i++)
      vec("freerun", K_N, 10'd0, 10'd0, 10'(i), 1'b0, 1'b0, 1'b1, 1'b0);
    vec("halt_set",   K_N, 10'd0, 10'd0, 10'd64, 1'b1, 1'b0, 1'b1, 1'b0);
    vec("halt_jump",  K_J, 10'd5, 10'd0, 10'd64, 1'b1, 1'b0, 1'b1, 1'b0);
    vec("halt_init",  K_I, 10'd0, 10'd0, 10'd0,  1'b0, 1'b0, 1'b1, 1'b0);

    vec("stall_call", K_S | K_C, 10'd20, 10'd0, 10'd0,  1'b0, 1'b0, 1'b1, 1'b0);
    vec("jump_br",    K_J | K_B, 10'd40, 10'd0, 10'd40, 1'b0, 1'b0, 1'b1, 1'b0);
    vec("init_call",  K_I | K_C, 10'd20, 10'd0, 10'd0,  1'b0, 1'b0, 1'b1, 1'b0);
    vec("post_init",  K_N,       10'd0,  10'd0, 10'd1,  1'b0, 1'b0, 1'b1, 1'b0);

    vec("call10",     K_C,       10'd10, 10'd0,   10'd10,   1'b0, 1'b0, 1'b0, 1'b0);
    vec("ret_call",   K_R | K_C, 10'd50, 10'd0,   10'd2,    1'b0, 1'b0, 1'b1, 1'b0);
    vec("rel_br",     K_L | K_B, 10'd0,  10'd3,   10'd5,    1'b0, 1'b0, 1'b1, 1'b0);
    vec("rel_wrap",   K_L,       10'd0,  10'h3FA, 10'd1023, 1'b0, 1'b0, 1'b1, 1'b0);
    vec("halt_stall", K_S,       10'd0,  10'd0,   10'd1023, 1'b1, 1'b0, 1'b1, 1'b0);
    vec("end_init",   K_I,       10'd0,  10'd0,   10'd0,    1'b0, 1'b0, 1'b1, 1'b0);

    @(negedge CLK);
    {init, stall, ret_en, call_en, jump_en, rel_en, branch_en} = 7'b0;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge CLK);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected outputs never observed, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
    $finish;
  end

endmodule
